// File: rtl/guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// guess_round_ctrl
// Sequencer for one Bulls-and-Cows game. It sits between the debounced
// digit-entry path and the strike/ball checker.
//   - Assembles four distinct BCD digits into a 16-bit guess.
//   - Strobes check_en on submit.
//   - Waits CHECK_LAT cycles, then latches strike/ball and counts attempts.
//   - Holds WIN/LOSE until new_game or rst.
//
// Optional feature: define GUESS_BACKSPACE_EN to add the 'del' input. A del
// pulse removes the newest digit while entry is open.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   digit_valid   one-cycle key-press pulse; digit is sampled with it
//   digit[3:0]    BCD key value
//   submit        one-cycle request to check the current guess
//   new_game      one-cycle restart request (same effect as reset)
//   del           (GUESS_BACKSPACE_EN only) one-cycle backspace request
//   strike/ball   checker results, valid CHECK_LAT cycles after check_en
//   guess[15:0]   four nibbles, oldest digit in the highest filled slot;
//                 an empty slot reads 4'hF
//   check_en      one-cycle strobe; guess is stable until result_valid
//   res_strike/res_ball  latched checker results
//   result_valid  high in SHOW, WIN and LOSE
//   tries[3:0]    completed attempts (saturates at MAX_TRIES)
//   win, lose     sticky game outcome
//   entry_err     one-cycle pulse on a rejected key, submit or del
// -----------------------------------------------------------------------------
module guess_round_ctrl #(
    parameter int MAX_TRIES   = 10,
    parameter int CHECK_LAT   = 2,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        submit,
    input  logic        new_game,
`ifdef GUESS_BACKSPACE_EN
    input  logic        del,
`endif
    input  logic [2:0]  strike,
    input  logic [2:0]  ball,
    output logic [15:0] guess,
    output logic        check_en,
    output logic [2:0]  res_strike,
    output logic [2:0]  res_ball,
    output logic        result_valid,
    output logic [3:0]  tries,
    output logic        win,
    output logic        lose,
    output logic        entry_err
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]        WAIT_LOAD = 4'(CHECK_LAT - 1);
    localparam logic [4:0]        TRY_LIMIT = 5'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_WAIT,
        ST_SHOW,
        ST_WIN,
        ST_LOSE
    } state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [3:0]        wait_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic key_dup;
    logic key_ok;
    logic sub_ok;

    // Empty slots hold 4'hF, which can never equal an accepted digit (<=9).
    // So all four nibbles can be compared regardless of cnt.
    always_comb begin
        key_dup = (guess[15:12] == digit) || (guess[11:8] == digit) ||
                  (guess[7:4]   == digit) || (guess[3:0]  == digit);
        key_ok  = (digit <= 4'd9) && (cnt < 3'd4) && !key_dup;
        sub_ok  = (cnt == 3'd4);
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state        <= ST_ENTRY;
            guess        <= 16'hFFFF;
            cnt          <= '0;
            wait_cnt     <= '0;
            hold_cnt     <= '0;
            check_en     <= 1'b0;
            res_strike   <= '0;
            res_ball     <= '0;
            result_valid <= 1'b0;
            tries        <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
            entry_err    <= 1'b0;
        end else begin
            check_en  <= 1'b0;
            entry_err <= 1'b0;
            case (state)
                ST_ENTRY: begin
`ifdef GUESS_BACKSPACE_EN
                    // del suppresses any key or submit in the same cycle.
                    if (del) begin
                        if (cnt != 3'd0) begin
                            guess <= {4'hF, guess[15:4]};
                            cnt   <= cnt - 3'd1;
                        end else begin
                            entry_err <= 1'b1;
                        end
                    end else
`endif
                    begin
                        // The key and the submit are judged independently,
                        // both against the pre-key cnt.
                        if (digit_valid && key_ok) begin
                            guess <= {guess[11:0], digit};
                            cnt   <= cnt + 3'd1;
                        end
                        if (submit && sub_ok) begin
                            state    <= ST_CHECK;
                            check_en <= 1'b1;
                        end
                        entry_err <= (digit_valid && !key_ok) ||
                                     (submit && !sub_ok);
                    end
                end

                ST_CHECK: begin
                    state    <= ST_WAIT;
                    wait_cnt <= WAIT_LOAD;
                end

                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        res_strike   <= strike;
                        res_ball     <= ball;
                        result_valid <= 1'b1;
                        if ({1'b0, tries} < TRY_LIMIT)
                            tries <= tries + 4'd1;
                        if (strike == 3'd4) begin
                            state <= ST_WIN;
                            win   <= 1'b1;
                        end else if (({1'b0, tries} + 5'd1) == TRY_LIMIT) begin
                            state <= ST_LOSE;
                            lose  <= 1'b1;
                        end else begin
                            state    <= ST_SHOW;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_SHOW: begin
                    if (hold_cnt == '0) begin
                        state        <= ST_ENTRY;
                        guess        <= 16'hFFFF;
                        cnt          <= '0;
                        result_valid <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                ST_WIN, ST_LOSE: begin
                    // Terminal states. Only new_game or rst leave them.
                end

                default: state <= ST_ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_round_ctrl.sv
module tb_guess_round_ctrl;

    localparam logic [15:0] ANSWER = 16'h1234;

    logic clk = 1'b0;
    logic rst, digit_valid, submit, new_game;
    logic [3:0] digit;
`ifdef GUESS_BACKSPACE_EN
    logic del;
`endif

    // dut_a: MAX_TRIES=10, dut_b: MAX_TRIES=3; both share the stimulus.
    logic [2:0]  strike_a = 3'd7, ball_a = 3'd7, strike_b = 3'd7, ball_b = 3'd7;
    logic [15:0] guess_a, guess_b;
    logic        check_en_a, check_en_b, result_valid_a, result_valid_b;
    logic [2:0]  res_strike_a, res_ball_a, res_strike_b, res_ball_b;
    logic [3:0]  tries_a, tries_b;
    logic        win_a, win_b, lose_a, lose_b, entry_err_a, entry_err_b;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    guess_round_ctrl #(.MAX_TRIES(10), .CHECK_LAT(2), .HOLD_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .submit(submit), .new_game(new_game),
`ifdef GUESS_BACKSPACE_EN
        .del(del),
`endif
        .strike(strike_a), .ball(ball_a), .guess(guess_a), .check_en(check_en_a),
        .res_strike(res_strike_a), .res_ball(res_ball_a),
        .result_valid(result_valid_a), .tries(tries_a), .win(win_a),
        .lose(lose_a), .entry_err(entry_err_a)
    );

    guess_round_ctrl #(.MAX_TRIES(3), .CHECK_LAT(2), .HOLD_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .submit(submit), .new_game(new_game),
`ifdef GUESS_BACKSPACE_EN
        .del(del),
`endif
        .strike(strike_b), .ball(ball_b), .guess(guess_b), .check_en(check_en_b),
        .res_strike(res_strike_b), .res_ball(res_ball_b),
        .result_valid(result_valid_b), .tries(tries_b), .win(win_b),
        .lose(lose_b), .entry_err(entry_err_b)
    );

    function automatic logic [2:0] calc_strike(input logic [15:0] g);
        logic [15:0] a;
        logic [2:0]  s;
        a = ANSWER;
        s = 3'd0;
        for (int i = 0; i < 4; i++)
            if (g[i*4 +: 4] == a[i*4 +: 4]) s = s + 3'd1;
        return s;
    endfunction

    function automatic logic [2:0] calc_ball(input logic [15:0] g);
        logic [15:0] a;
        logic [2:0]  b;
        a = ANSWER;
        b = 3'd0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i != j && g[i*4 +: 4] == a[j*4 +: 4]) b = b + 3'd1;
        return b;
    endfunction

    // Checker model with a latency of 2 cycles. The result is valid for
    // exactly one cycle; otherwise the checker drives 7, which is never a
    // legal count.
    logic d1_a = 1'b0, d1_b = 1'b0;
    always @(posedge clk) begin
        d1_a <= check_en_a;
        d1_b <= check_en_b;
        strike_a <= d1_a ? calc_strike(guess_a) : 3'd7;
        ball_a   <= d1_a ? calc_ball(guess_a)   : 3'd7;
        strike_b <= d1_b ? calc_strike(guess_b) : 3'd7;
        ball_b   <= d1_b ? calc_ball(guess_b)   : 3'd7;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        @(negedge clk); digit_valid = 1'b1; digit = d;
        @(negedge clk); digit_valid = 1'b0;
    endtask

    task automatic do_submit;
        @(negedge clk); submit = 1'b1;
        @(negedge clk); submit = 1'b0;
    endtask

    task automatic start_game;
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_n(3);
        vec++; if (guess_a !== 16'hFFFF) begin err++; $display("FAIL rst_guess: got %h want ffff", guess_a); end
        vec++; if ({check_en_a, result_valid_a, win_a, lose_a, entry_err_a} !== 5'b0) begin err++; $display("FAIL rst_flags: got %b want 00000", {check_en_a, result_valid_a, win_a, lose_a, entry_err_a}); end
        vec++; if ({tries_a, res_strike_a, res_ball_a} !== 10'd0) begin err++; $display("FAIL rst_counts: got %h want 0", {tries_a, res_strike_a, res_ball_a}); end
        rst = 1'b0;
        wait_n(1);
    endtask

    task automatic test_win;
        start_game;
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        vec++; if (guess_a !== 16'h1234) begin err++; $display("FAIL win_guess: got %h want 1234", guess_a); end
        do_submit;
        vec++; if (check_en_a !== 1'b1) begin err++; $display("FAIL win_check_en: got %b want 1", check_en_a); end
        wait_n(1);
        vec++; if (check_en_a !== 1'b0) begin err++; $display("FAIL win_check_en_drop: got %b want 0", check_en_a); end
        wait_n(1);
        vec++; if (result_valid_a !== 1'b0) begin err++; $display("FAIL win_early_valid: got %b want 0", result_valid_a); end
        wait_n(1);
        vec++; if ({result_valid_a, win_a, lose_a} !== 3'b110) begin err++; $display("FAIL win_flags: got %b want 110", {result_valid_a, win_a, lose_a}); end
        vec++; if ({res_strike_a, res_ball_a, tries_a} !== {3'd4, 3'd0, 4'd1}) begin err++; $display("FAIL win_result: got s%0d b%0d t%0d want s4 b0 t1", res_strike_a, res_ball_a, tries_a); end
        wait_n(6);
        vec++; if ({result_valid_a, win_a} !== 2'b11) begin err++; $display("FAIL win_hold: got %b want 11", {result_valid_a, win_a}); end
        key(4'd5);
        vec++; if ({guess_a, entry_err_a} !== {16'h1234, 1'b0}) begin err++; $display("FAIL win_key_ignored: got %h/%b want 1234/0", guess_a, entry_err_a); end
        do_submit;
        vec++; if ({check_en_a, entry_err_a} !== 2'b00) begin err++; $display("FAIL win_submit_ignored: got %b want 00", {check_en_a, entry_err_a}); end
    endtask

    task automatic test_show;
        start_game;
        key(4'd4); key(4'd3); key(4'd2); key(4'd1);
        do_submit;
        wait_n(3);
        vec++; if ({res_strike_a, res_ball_a, tries_a} !== {3'd0, 3'd4, 4'd1}) begin err++; $display("FAIL show_result: got s%0d b%0d t%0d want s0 b4 t1", res_strike_a, res_ball_a, tries_a); end
        vec++; if ({result_valid_a, win_a, lose_a} !== 3'b100) begin err++; $display("FAIL show_flags: got %b want 100", {result_valid_a, win_a, lose_a}); end
        wait_n(3);
        vec++; if (result_valid_a !== 1'b1) begin err++; $display("FAIL show_last_cycle: got %b want 1", result_valid_a); end
        wait_n(1);
        vec++; if ({result_valid_a, guess_a} !== {1'b0, 16'hFFFF}) begin err++; $display("FAIL show_exit: got %b/%h want 0/ffff", result_valid_a, guess_a); end
        vec++; if ({res_ball_a, tries_a} !== {3'd4, 4'd1}) begin err++; $display("FAIL show_retain: got b%0d t%0d want b4 t1", res_ball_a, tries_a); end
    endtask

    task automatic test_reject;
        start_game;
        key(4'd5);
        vec++; if ({guess_a, entry_err_a} !== {16'hFFF5, 1'b0}) begin err++; $display("FAIL rej_first: got %h/%b want fff5/0", guess_a, entry_err_a); end
        key(4'd5);
        vec++; if ({guess_a, entry_err_a} !== {16'hFFF5, 1'b1}) begin err++; $display("FAIL rej_dup: got %h/%b want fff5/1", guess_a, entry_err_a); end
        wait_n(1);
        vec++; if (entry_err_a !== 1'b0) begin err++; $display("FAIL rej_pulse_len: got %b want 0", entry_err_a); end
        key(4'hA);
        vec++; if ({guess_a, entry_err_a} !== {16'hFFF5, 1'b1}) begin err++; $display("FAIL rej_non_bcd: got %h/%b want fff5/1", guess_a, entry_err_a); end
        do_submit;
        vec++; if ({check_en_a, entry_err_a} !== 2'b01) begin err++; $display("FAIL rej_submit: got %b want 01", {check_en_a, entry_err_a}); end
    endtask

    task automatic test_same_cycle;
        start_game;
        key(4'd1); key(4'd2); key(4'd3);
        @(negedge clk); digit_valid = 1'b1; digit = 4'd4; submit = 1'b1;
        @(negedge clk); digit_valid = 1'b0; submit = 1'b0;
        vec++; if ({guess_a, check_en_a, entry_err_a} !== {16'h1234, 2'b01}) begin err++; $display("FAIL same_cycle: got %h/%b/%b want 1234/0/1", guess_a, check_en_a, entry_err_a); end
        key(4'd5);
        vec++; if ({guess_a, entry_err_a} !== {16'h1234, 1'b1}) begin err++; $display("FAIL full_reject: got %h/%b want 1234/1", guess_a, entry_err_a); end
        do_submit;
        vec++; if ({check_en_a, entry_err_a} !== 2'b10) begin err++; $display("FAIL full_submit: got %b want 10", {check_en_a, entry_err_a}); end
        wait_n(4);
    endtask

    task automatic test_lose;
        start_game;
        for (int t = 0; t < 3; t++) begin
            key(4'd5); key(4'd6); key(4'd7); key(4'd8);
            do_submit;
            wait_n(3);
            if (t < 2) begin
                vec++; if ({tries_b, lose_b, result_valid_b} !== {4'(t + 1), 2'b01}) begin err++; $display("FAIL lose_attempt%0d: got t%0d l%b v%b want t%0d l0 v1", t, tries_b, lose_b, result_valid_b, t + 1); end
                wait_n(4);
            end
        end
        vec++; if ({tries_b, lose_b, win_b, result_valid_b} !== {4'd3, 3'b101}) begin err++; $display("FAIL lose_final: got t%0d l%b w%b v%b want t3 l1 w0 v1", tries_b, lose_b, win_b, result_valid_b); end
        vec++; if ({res_strike_b, res_ball_b} !== 6'd0) begin err++; $display("FAIL lose_result: got s%0d b%0d want s0 b0", res_strike_b, res_ball_b); end
        vec++; if ({lose_a, tries_a} !== {1'b0, 4'd3}) begin err++; $display("FAIL lose_max10: got l%b t%0d want l0 t3", lose_a, tries_a); end
        wait_n(6);
        key(4'd1);
        vec++; if ({guess_b, lose_b, entry_err_b} !== {16'h5678, 2'b10}) begin err++; $display("FAIL lose_frozen: got %h/%b/%b want 5678/1/0", guess_b, lose_b, entry_err_b); end
        start_game;
        vec++; if ({guess_b, tries_b, res_strike_b, res_ball_b} !== {16'hFFFF, 10'd0}) begin err++; $display("FAIL lose_new_game: got %h t%0d s%0d b%0d want ffff 0 0 0", guess_b, tries_b, res_strike_b, res_ball_b); end
        vec++; if ({check_en_b, result_valid_b, win_b, lose_b, entry_err_b} !== 5'b0) begin err++; $display("FAIL lose_new_game_flags: got %b want 00000", {check_en_b, result_valid_b, win_b, lose_b, entry_err_b}); end
    endtask

    task automatic test_abort;
        start_game;
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        do_submit;
        start_game;
        vec++; if ({result_valid_a, tries_a, guess_a} !== {1'b0, 4'd0, 16'hFFFF}) begin err++; $display("FAIL abort_now: got v%b t%0d %h want v0 t0 ffff", result_valid_a, tries_a, guess_a); end
        wait_n(4);
        vec++; if ({result_valid_a, win_a, tries_a, res_strike_a} !== 9'd0) begin err++; $display("FAIL abort_late_strike: got v%b w%b t%0d s%0d want all 0", result_valid_a, win_a, tries_a, res_strike_a); end
    endtask

`ifdef GUESS_BACKSPACE_EN
    task automatic test_backspace;
        start_game;
        key(4'd1); key(4'd2); key(4'd3);
        @(negedge clk); del = 1'b1;
        @(negedge clk); del = 1'b0;
        vec++; if ({guess_a, entry_err_a} !== {16'hFF12, 1'b0}) begin err++; $display("FAIL bs_del: got %h/%b want ff12/0", guess_a, entry_err_a); end
        key(4'd4);
        vec++; if (guess_a !== 16'hF124) begin err++; $display("FAIL bs_refill: got %h want f124", guess_a); end
        start_game;
        @(negedge clk); del = 1'b1;
        @(negedge clk); del = 1'b0;
        vec++; if ({guess_a, entry_err_a} !== {16'hFFFF, 1'b1}) begin err++; $display("FAIL bs_empty: got %h/%b want ffff/1", guess_a, entry_err_a); end
        key(4'd5);
        @(negedge clk); del = 1'b1; digit_valid = 1'b1; digit = 4'd6;
        @(negedge clk); del = 1'b0; digit_valid = 1'b0;
        vec++; if ({guess_a, entry_err_a} !== {16'hFFFF, 1'b0}) begin err++; $display("FAIL bs_priority: got %h/%b want ffff/0", guess_a, entry_err_a); end
    endtask
`endif

    initial begin
        rst = 1'b1; digit_valid = 1'b0; digit = 4'd0; submit = 1'b0; new_game = 1'b0;
`ifdef GUESS_BACKSPACE_EN
        del = 1'b0;
`endif
        test_reset;
        test_win;
        test_show;
        test_reject;
        test_same_cycle;
        test_lose;
        test_abort;
`ifdef GUESS_BACKSPACE_EN
        test_backspace;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
- Sequencer for one Bulls-and-Cows game, placed between the debounced digit-entry path and the strike/ball checker.
- Assembles four distinct decimal digits into a 16-bit guess and issues a one-cycle check strobe on submit.
- Waits a fixed checker latency, then latches strike/ball and counts attempts.
- Declares WIN or LOSE, holding the result for the LCD and LED blocks until a new game starts.

Parameters:
- MAX_TRIES, 10: attempts allowed before LOSE; legal range 1..15.
- CHECK_LAT, 2: cycles from check_en to valid strike/ball at the inputs; legal range 1..15.
- HOLD_CYCLES, 50000000: cycles result_valid is held in SHOW before entry reopens; must be >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- digit_valid  in  1  one-cycle pulse: a key was pressed.
- digit  in  4  BCD key value; sampled only when digit_valid=1.
- submit  in  1  one-cycle pulse: request a check of the current guess.
- new_game  in  1  one-cycle pulse: abandon or finish the current game and restart.
- strike  in  3  checker strike count, 0..4.
- ball  in  3  checker ball count, 0..4.
- guess  out  16  four nibbles, MSB nibble first; an empty slot is 4'hF.
- check_en  out  1  one-cycle strobe; guess is stable from this cycle until result_valid.
- res_strike  out  3  latched strike count.
- res_ball  out  3  latched ball count.
- result_valid  out  1  high in SHOW, WIN and LOSE.
- tries  out  4  attempts completed.
- win  out  1  game won (sticky until new_game or rst).
- lose  out  1  game lost (sticky until new_game or rst).
- entry_err  out  1  one-cycle pulse on a rejected key or submit.

Behaviour:
- Reset, synchronous on rst=1: state=ENTRY, guess=16'hFFFF, cnt=0, check_en=0, res_strike=0, res_ball=0, result_valid=0, tries=0, win=0, lose=0, entry_err=0.
- Priority: rst > new_game > all other inputs.
- new_game in any state: same values as reset on the next edge.
- States: ENTRY, CHECK, WAIT, SHOW, WIN, LOSE.
- ENTRY, digit_valid=1: the key is accepted iff digit<=9, cnt<4, and digit does not match any filled nibble.
  - Accept: guess <= {guess[11:0], digit}; cnt++.
  - Reject: guess is unchanged; entry_err pulses on the next cycle.
- ENTRY, submit=1:
  - cnt==4: go to CHECK.
  - cnt<4: entry_err pulses; stay in ENTRY.
  - digit_valid=1 in the same cycle: the digit is processed first; the submit is evaluated against the pre-digit cnt.
- CHECK: lasts exactly 1 cycle. check_en=1. Go to WAIT and load the wait counter with CHECK_LAT-1.
- WAIT: count down. At 0:
  - Latch strike/ball into res_*; tries++.
  - If strike==4: go to WIN, win=1.
  - Else if tries+1==MAX_TRIES: go to LOSE, lose=1.
  - Else: go to SHOW, load the hold counter with HOLD_CYCLES-1.
- SHOW: result_valid=1. At hold counter 0: go to ENTRY; guess=16'hFFFF; cnt=0; result_valid drops; res_* are retained.
- WIN and LOSE: terminal states; result_valid=1; guess is frozen.
- Keys and submit outside ENTRY: ignored; no error pulse.
- Latency: submit edge to check_en = 1 cycle. check_en to result_valid = CHECK_LAT+1 cycles.
- strike or ball >4: passed through unmodified. Win is detected only on strike==4.
- tries saturates at MAX_TRIES.

Optional Feature:
- Macro: GUESS_BACKSPACE_EN.
- When defined:
  - Adds input port del (1 bit; one-cycle pulse).
  - In ENTRY with cnt>0: guess <= {4'hF, guess[15:4]}; cnt--. This removes the newest digit and right-aligns the remaining digits.
  - cnt==0: entry_err pulses.
  - Priority: del beats digit_valid in the same cycle; the digit is dropped with no error pulse. del beats submit; submit is ignored.
- When not defined: no del port; entry is append-only.

Test Plan:
- Setup for all scenarios: bench checker model with answer 16'h1234 and CHECK_LAT=2; HOLD_CYCLES=4 for sim.
- Keys 1,2,3,4 then submit -> guess=16'h1234; check_en for 1 cycle; 3 cycles later res_strike=4, res_ball=0, win=1, tries=1, result_valid stays high.
- Keys 4,3,2,1 then submit -> res_strike=0, res_ball=4, tries=1; SHOW for 4 cycles; then ENTRY with guess=16'hFFFF.
- Keys 5,5 -> second 5 rejected; guess=16'hFFF5; entry_err pulses once. Key 4'hA rejected. Submit with cnt=1 -> entry_err; no check_en.
- MAX_TRIES=3; three wrong guesses 5678 -> tries=3, lose=1, strike=0, ball=0. Further keys are ignored. new_game -> all outputs at reset values.
- new_game asserted during WAIT -> next cycle ENTRY, tries=0. A strike value arriving later is not latched.
- With GUESS_BACKSPACE_EN: keys 1,2,3, del, 4 -> guess=16'hF124. del at cnt=0 -> entry_err.
